// File: rtl/ula_raster_gen_pkg.sv
// Shared timing-set type, preset raster geometries and default counter widths
// for the ULA raster generator.
package ula_timing_pkg;

  localparam int CW_DEF = 9;
  localparam int VW_DEF = 9;

  typedef struct packed {
    logic [15:0] htotal;
    logic [15:0] vtotal;
  } timing_set_t;

  localparam timing_set_t SPEC48   = '{htotal: 16'd448, vtotal: 16'd312};
  localparam timing_set_t SPEC128  = '{htotal: 16'd456, vtotal: 16'd311};
  localparam timing_set_t PENTAGON = '{htotal: 16'd448, vtotal: 16'd320};

  // Half-open window test: lo <= val < hi.
  function automatic logic in_window(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/ula_raster_gen_if.sv
// Raster timing bundle: the ALT select into the generator and every decoded
// timing output toward video fetch, shifter, contention and the CPU.
interface ula_raster_gen_if #(
  parameter int CW = 9,
  parameter int VW = 9
);
  logic          ALT;
  logic          CLK7_EN;
  logic [CW-1:0] C;
  logic [VW-1:0] V;
  logic          HBLANK;
  logic          VBLANK;
  logic          HSYNC;
  logic          VSYNC;
  logic          PAPER;
  logic          n_INT;
  logic          FLASH;
  logic          LINE_START;
  logic          FRAME_START;
  logic          MODE_Q;

  modport master (
    input  ALT,
    output CLK7_EN, C, V, HBLANK, VBLANK, HSYNC, VSYNC, PAPER,
           n_INT, FLASH, LINE_START, FRAME_START, MODE_Q
  );

  modport slave (
    output ALT,
    input  CLK7_EN, C, V, HBLANK, VBLANK, HSYNC, VSYNC, PAPER,
           n_INT, FLASH, LINE_START, FRAME_START, MODE_Q
  );
endinterface

// File: rtl/ula_raster_gen_wrap_counter.sv
// Up-counter with enable and runtime modulus; exposes its next value so the
// parent can register decodes with zero lag, plus the wrap flag.
module ula_wrap_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W:0]   modulus,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last;

  always_comb begin
    at_last = ({1'b0, count_q} == (modulus - (W+1)'(1)));
    wrap    = en && at_last;
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/ula_raster_gen.sv
// ULA raster generator: CLK7 enable, C/V counters, registered timing decode,
// frame interrupt and flash clock, with the timing set switched only at frame wrap.
module ula_raster_gen
  import ula_timing_pkg::*;
#(
  parameter int CW           = CW_DEF,
  parameter int VW           = VW_DEF,
  parameter int H_TOTAL      = int'(SPEC48.htotal),
  parameter int V_TOTAL      = int'(SPEC48.vtotal),
  parameter int H_TOTAL_ALT  = int'(SPEC128.htotal),
  parameter int V_TOTAL_ALT  = int'(SPEC128.vtotal),
  parameter int H_ACTIVE     = 256,
  parameter int V_ACTIVE     = 192,
  parameter int HBLANK_START = 320,
  parameter int HBLANK_END   = 416,
  parameter int HSYNC_START  = 344,
  parameter int HSYNC_END    = 376,
  parameter int VSYNC_START  = 248,
  parameter int VSYNC_END    = 252,
  parameter int VBLANK_END   = 256,
  parameter int INT_LINE     = 248,
  parameter int INT_LEN      = 32,
  parameter int FLASH_FRAMES = 16
) (
  input logic              OSC,
  input logic              n_RES,
  ula_raster_gen_if.master bus
);

  localparam timing_set_t SET_PRI = '{htotal: 16'(H_TOTAL), vtotal: 16'(V_TOTAL)};
  localparam timing_set_t SET_ALT = '{htotal: 16'(H_TOTAL_ALT), vtotal: 16'(V_TOTAL_ALT)};
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  if (CW > 15 || VW > 15) begin : g_bad_width
    $error("ula_raster_gen: CW/VW must fit the 16-bit timing-set fields");
  end
  if (H_TOTAL > (1 << CW) || H_TOTAL_ALT > (1 << CW) || H_TOTAL < 2 || H_TOTAL_ALT < 2) begin : g_bad_htotal
    $error("ula_raster_gen: horizontal totals must lie in 2..2^CW");
  end
  if (V_TOTAL > (1 << VW) || V_TOTAL_ALT > (1 << VW) || V_TOTAL < 1 || V_TOTAL_ALT < 1) begin : g_bad_vtotal
    $error("ula_raster_gen: vertical totals must lie in 1..2^VW");
  end
  if (HBLANK_START >= HBLANK_END || HSYNC_START >= HSYNC_END ||
      VSYNC_START >= VSYNC_END || VSYNC_START >= VBLANK_END) begin : g_bad_window
    $error("ula_raster_gen: every window start must precede its end");
  end
  if (FLASH_FRAMES < 1) begin : g_bad_flash
    $error("ula_raster_gen: FLASH_FRAMES must be at least 1");
  end

  logic          phase_q, phase_d;
  logic          clk7_en_q, clk7_en_d;
  logic          first_q, first_d;
  logic          mode_q, mode_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          paper_q, paper_d;
  logic          n_int_q, n_int_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic [CW:0]   h_mod;
  logic [VW:0]   v_mod;
  logic [CW-1:0] c_cnt, c_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          c_wrap, v_wrap;

  assign h_mod = mode_q ? SET_ALT.htotal[CW:0] : SET_PRI.htotal[CW:0];
  assign v_mod = mode_q ? SET_ALT.vtotal[VW:0] : SET_PRI.vtotal[VW:0];

  ula_wrap_counter #(.W(CW)) u_c_cnt (
    .clk        (OSC),
    .rst_n      (n_RES),
    .en         (clk7_en_q),
    .modulus    (h_mod),
    .count      (c_cnt),
    .count_next (c_next),
    .wrap       (c_wrap)
  );

  ula_wrap_counter #(.W(VW)) u_v_cnt (
    .clk        (OSC),
    .rst_n      (n_RES),
    .en         (c_wrap),
    .modulus    (v_mod),
    .count      (v_cnt),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decodes are taken from the counters' next values so each registered flag
  // lines up with the C/V it describes in the same cycle.
  always_comb begin
    phase_d     = ~phase_q;
    clk7_en_d   = phase_q;
    first_d     = 1'b0;
    mode_d      = (first_q || v_wrap) ? bus.ALT : mode_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    if (v_wrap) begin
      if (flash_cnt_q == FW'(FLASH_FRAMES - 1)) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FW'(1);
      end
    end
    hblank_d      = in_window(int'(c_next), HBLANK_START, HBLANK_END);
    hsync_d       = in_window(int'(c_next), HSYNC_START, HSYNC_END);
    vblank_d      = in_window(int'(v_next), VSYNC_START, VBLANK_END);
    vsync_d       = in_window(int'(v_next), VSYNC_START, VSYNC_END);
    paper_d       = (int'(c_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
    n_int_d       = !((int'(v_next) == INT_LINE) && (int'(c_next) < INT_LEN));
    line_start_d  = c_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge OSC or negedge n_RES) begin
    if (!n_RES) begin
      phase_q       <= 1'b0;
      clk7_en_q     <= 1'b0;
      first_q       <= 1'b1;
      mode_q        <= 1'b0;
      flash_cnt_q   <= '0;
      flash_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      paper_q       <= 1'b1;
      n_int_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      clk7_en_q     <= clk7_en_d;
      first_q       <= first_d;
      mode_q        <= mode_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_q       <= flash_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      paper_q       <= paper_d;
      n_int_q       <= n_int_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.CLK7_EN     = clk7_en_q;
  assign bus.C           = c_cnt;
  assign bus.V           = v_cnt;
  assign bus.HBLANK      = hblank_q;
  assign bus.VBLANK      = vblank_q;
  assign bus.HSYNC       = hsync_q;
  assign bus.VSYNC       = vsync_q;
  assign bus.PAPER       = paper_q;
  assign bus.n_INT       = n_int_q;
  assign bus.FLASH       = flash_q;
  assign bus.LINE_START  = line_start_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.MODE_Q      = mode_q;

endmodule

// File: doc/ula_raster_gen.md
Name: ula_raster_gen

Overview:
- Parametrised successor to the fixed ULA C/V cadence counters.
- Divides OSC by 2 into a CLK7 enable and runs a horizontal pixel counter C and a vertical line counter V.
- Decodes blanking, sync, paper area, the frame interrupt n_INT and the flash clock.
- Supports a second timing set (e.g. 48K vs 128K) selected at runtime; the selection is applied only on a frame boundary.
- Feeds the video address generator, the pixel shift register, the contention handler and the CPU interrupt pin.

Parameters:
CW, 9, width of C
VW, 9, width of V
H_TOTAL, 448, pixels per line, primary set
V_TOTAL, 312, lines per frame, primary set
H_TOTAL_ALT, 456, pixels per line, alternate set
V_TOTAL_ALT, 311, lines per frame, alternate set
H_ACTIVE, 256, paper width in pixels
V_ACTIVE, 192, paper height in lines
HBLANK_START, 320, first C of horizontal blank
HBLANK_END, 416, first C after horizontal blank
HSYNC_START, 344, first C of horizontal sync
HSYNC_END, 376, first C after horizontal sync
VSYNC_START, 248, first V of vertical sync and vertical blank
VSYNC_END, 252, first V after vertical sync
VBLANK_END, 256, first V after vertical blank
INT_LINE, 248, V on which n_INT fires
INT_LEN, 32, n_INT low width in CLK7 steps, starting at C=0
FLASH_FRAMES, 16, frames per flash half-period

Ports:
OSC  in  1  master clock (14 MHz)
n_RES  in  1  asynchronous active-low reset
ALT  in  1  timing set select: 0 = primary, 1 = alternate; sampled at frame wrap
CLK7_EN  out  1  high on every second OSC cycle; counters advance only when high
C  out  CW  current pixel counter
V  out  VW  current line counter
HBLANK  out  1  horizontal blank
VBLANK  out  1  vertical blank
HSYNC  out  1  horizontal sync, active high
VSYNC  out  1  vertical sync, active high
PAPER  out  1  inside the H_ACTIVE × V_ACTIVE area
n_INT  out  1  frame interrupt, active low
FLASH  out  1  flash clock
LINE_START  out  1  one-OSC pulse when C wraps to 0
FRAME_START  out  1  one-OSC pulse when V wraps to 0
MODE_Q  out  1  timing set currently in force

Behaviour:
- Clock and reset:
  - One clock, OSC.
  - Asynchronous active-low reset n_RES; clears all state immediately on assertion, regardless of the OSC edge.
- Reset values:
  - phase=0, CLK7_EN=0, C=0, V=0, flash counter=0, FLASH=0.
  - MODE_Q = ALT as sampled while in reset (registered on the first OSC edge after release).
  - HBLANK=0, VBLANK=0, HSYNC=0, VSYNC=0, PAPER=1, n_INT=1, LINE_START=0, FRAME_START=0.
- CLK7 enable:
  - phase toggles every OSC edge.
  - CLK7_EN is the registered phase==1 and is high on alternate OSC cycles, starting with the second edge after reset release.
- Counting (only when CLK7_EN=1):
  - C increments. If C == HT-1 then C←0, and V increments. If V == VT-1 then V←0.
  - HT/VT are H_TOTAL/V_TOTAL when MODE_Q=0, and the _ALT values when MODE_Q=1.
- Mode switch:
  - MODE_Q←ALT only on the frame wrap step (C==HT-1 && V==VT-1 && CLK7_EN).
  - A mid-frame ALT change never alters the current frame length.
- Decode:
  - All decoded outputs are registered and always equal the decode of the C/V values presented in the same cycle, so there is zero lag to the counters and no glitches.
  - HBLANK = HBLANK_START ≤ C < HBLANK_END.
  - HSYNC = HSYNC_START ≤ C < HSYNC_END.
  - VBLANK = VSYNC_START ≤ V < VBLANK_END.
  - VSYNC = VSYNC_START ≤ V < VSYNC_END.
  - PAPER = C < H_ACTIVE && V < V_ACTIVE.
  - n_INT = 0 iff V == INT_LINE && C < INT_LEN.
- Pulses:
  - LINE_START is high for exactly the one OSC cycle in which C first shows 0.
  - FRAME_START is high likewise for V=0, and is coincident with LINE_START.
- Flash:
  - The flash counter increments on each frame wrap.
  - At FLASH_FRAMES-1 the counter returns to 0 and FLASH toggles.
- Edge cases:
  - Reset mid-line, mid-INT or mid-sync returns every output to its reset value in the same instant; no partial pulse completes.
  - Frame wrap coincident with an ALT change: the new set governs from C=0, V=0 onward.
  - If INT_LINE ≥ VT in the active set, n_INT never asserts.
- Elaboration checks: each total ≤ 2^CW or 2^VW as appropriate, and every *_START < *_END.

Decomposition:
- Package ula_timing_pkg holds:
  - the timing-set struct (htotal, vtotal);
  - localparam presets SPEC48, SPEC128, PENTAGON;
  - the default widths.
- One sub-module, ula_wrap_counter: a width-parametrised counter with enable and runtime modulus that outputs the wrap flag. It is instantiated twice, once for C and once for V, with V enabled by the C wrap.

Test Plan:
- Reset: assert n_RES while C=100, V=50 with OSC stopped → C=0, V=0, n_INT=1, PAPER=1 with no clock edge.
- Line wrap: defaults, C=447 on a CLK7_EN step → C=0, V+1, LINE_START high for one OSC cycle.
- Frame and INT:
  - V=311, C=447 wrap → V=0, FRAME_START pulse.
  - n_INT low for exactly 64 OSC cycles at V=248.
  - Frame period is 279552 OSC cycles.
- Mode switch: ALT←1 at V=100 → current frame still 279552 OSC cycles, MODE_Q=1 at wrap, next frame 283632 cycles (456×311×2).
- Flash: run 32 frames from reset → FLASH toggles at the end of frames 16 and 32.
- Sync windows: sweep one line → HSYNC high for C=344..375, HBLANK high for C=320..415, PAPER high only for C<256 on V<192.
